// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity and stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      parity_error,
    output logic                      stop_error
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]          BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]          BIT_ONE  = BIT_W'(32'd1);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(32'd1);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_TWO  = PRESCALE_WIDTH'(32'd2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic                        rx_s;
    logic [PRESCALE_WIDTH-1:0]   prescale_r;
    logic [PRESCALE_WIDTH-1:0]   edge_cnt_r;
    logic [PRESCALE_WIDTH-1:0]   half_s;
    logic                        pe_r;
    logic                        ptype_r;
    logic [BIT_W-1:0]            bit_cnt_r;
    logic [2:0]                  samp_r;
    logic [DATA_WIDTH-1:0]       shift_r;
    logic                        par_err_r;
    logic                        voted_s;
    logic                        mid_s;
    logic                        last_s;
    logic                        start_s;
    logic                        dv_nxt_s;
    logic                        perr_nxt_s;
    logic                        serr_nxt_s;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer; resets high so reset release never fakes a start bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RX_IN};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = RX_IN;
`endif

    assign half_s  = {1'b0, prescale_r[PRESCALE_WIDTH-1:1]};
    assign mid_s   = (edge_cnt_r == (half_s + CNT_ONE));
    assign last_s  = (edge_cnt_r == (prescale_r - CNT_ONE));
    assign voted_s = maj3(samp_r);
    assign start_s = (state_r == ST_IDLE) && !rx_s;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and frame-evaluation decode
    always_comb begin
        state_nxt_s = state_r;
        dv_nxt_s    = 1'b0;
        perr_nxt_s  = 1'b0;
        serr_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                // A start bit that votes high was only a glitch on the line
                if (mid_s && voted_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (last_s && (bit_cnt_r == BIT_LAST)) begin
                    state_nxt_s = pe_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (last_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                    if (!voted_s) begin
                        serr_nxt_s = 1'b1;
                        perr_nxt_s = par_err_r;
                    end else if (par_err_r) begin
                        perr_nxt_s = 1'b1;
                    end else begin
                        dv_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame configuration captured at start detect so mid-frame input changes are ignored
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_r <= '0;
            pe_r       <= 1'b0;
            ptype_r    <= 1'b0;
        end else if (start_s) begin
            prescale_r <= Prescale;
            pe_r       <= parity_enable;
            ptype_r    <= parity_type;
        end
    end

    // Edge counter within a bit and data bit counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_r <= '0;
            bit_cnt_r  <= '0;
        end else begin
            if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE) || last_s) begin
                edge_cnt_r <= '0;
            end else begin
                edge_cnt_r <= edge_cnt_r + CNT_ONE;
            end
            if (state_r == ST_IDLE) begin
                bit_cnt_r <= '0;
            end else if ((state_r == ST_DATA) && last_s) begin
                bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? '0 : (bit_cnt_r + BIT_ONE);
            end
        end
    end

    // Mid-bit sampling, data shift (LSB first) and parity check
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_r    <= 3'b111;
            shift_r   <= '0;
            par_err_r <= 1'b0;
        end else begin
            if (state_r != ST_IDLE) begin
                if (edge_cnt_r == (half_s - CNT_TWO)) begin
                    samp_r[0] <= rx_s;
                end
                if (edge_cnt_r == (half_s - CNT_ONE)) begin
                    samp_r[1] <= rx_s;
                end
                if (edge_cnt_r == half_s) begin
                    samp_r[2] <= rx_s;
                end
            end
            if ((state_r == ST_DATA) && mid_s) begin
                shift_r <= {voted_s, shift_r[DATA_WIDTH-1:1]};
            end
            if (start_s) begin
                par_err_r <= 1'b0;
            end else if ((state_r == ST_PARITY) && mid_s) begin
                par_err_r <= (voted_s != parity_bit(shift_r, ptype_r));
            end
        end
    end

    // Registered result strobes; P_DATA only updates on a good frame
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            Data_Valid   <= dv_nxt_s;
            parity_error <= perr_nxt_s;
            stop_error   <= serr_nxt_s;
            if (dv_nxt_s) begin
                P_DATA <= shift_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = 6'd8;
    logic          parity_enable = 1'b0;
    logic          parity_type = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          parity_error;
    logic          stop_error;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .parity_enable(parity_enable), .parity_type(parity_type),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .parity_error(parity_error), .stop_error(stop_error)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned   stamp;
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic [DW-1:0] good_word = '0;
    int unsigned   rx_free = 0;

    // Every cycle with any strobe high becomes one observed event
    always @(negedge CLK) begin
        if (Data_Valid || parity_error || stop_error)
            obs_q.push_back('{cyc, Data_Valid, parity_error, stop_error, P_DATA});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one frame and record the outcome the receiver must produce; called at a negedge
    task automatic send_frame(input logic [DW-1:0] data, input int p, input bit pe, input bit pt,
                              input bit par_ok, input bit stop_bit, input bit scramble);
        int          nbits;
        bit          pgood;
        int unsigned a;
        ev_t         e;
        Prescale      = PW'(p);
        parity_enable = pe;
        parity_type   = pt;
        nbits = 2 + DW + (pe ? 1 : 0);
        pgood = (($countones(data) % 2) == 1) ^ pt;
        a = cyc + 1 + SYNC_LAT;
        if (a < rx_free) a = rx_free;
        RX_IN = 1'b0;
        repeat (p / 2) @(negedge CLK);
        if (scramble) begin
            Prescale      = PW'($urandom);
            parity_enable = 1'($urandom);
            parity_type   = 1'($urandom);
        end
        repeat (p - p / 2) @(negedge CLK);
        for (int i = 0; i < DW; i++) begin
            RX_IN = data[i];
            repeat (p) @(negedge CLK);
        end
        if (pe) begin
            RX_IN = par_ok ? pgood : ~pgood;
            repeat (p) @(negedge CLK);
        end
        RX_IN = stop_bit;
        repeat (p) @(negedge CLK);
        RX_IN = 1'b1;
        e.stamp = a + nbits * p;
        e.pe    = pe && !par_ok;
        e.se    = !stop_bit;
        e.dv    = !e.pe && !e.se;
        if (e.dv) good_word = data;
        e.data  = good_word;
        exp_q.push_back(e);
        rx_free = a + nbits * p + 1;
    endtask

    task automatic check_events(input string tag);
        int budget = 400;
        ev_t o;
        ev_t x;
        while ((obs_q.size() < exp_q.size()) && (budget > 0)) begin
            @(negedge CLK);
            budget--;
        end
        repeat (4 + SYNC_LAT) @(negedge CLK);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            chk({tag, "_time"}, 64'(o.stamp), 64'(x.stamp));
            chk({tag, "_flags"}, 64'({o.dv, o.pe, o.se}), 64'({x.dv, x.pe, x.se}));
            chk({tag, "_pdata"}, 64'(o.data), 64'(x.data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_pdata", 64'(P_DATA), 64'd0);
        chk("reset_strobes", 64'({Data_Valid, parity_error, stop_error}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_events("t1_8n1");

        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_events("t2_even_ok");
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_events("t2_even_bad");

        send_frame(8'h01, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_events("t3_stop_err");

        // Two-cycle glitch must be rejected without any strobe
        Prescale = 6'd16;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        check_events("t4_glitch");
        rx_free = 0;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_events("t4_after");

        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_events("t5_b2b");

        // Reset in the middle of the data bits of 0x81
        Prescale = 6'd8;
        parity_enable = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (12) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t6_rst_pdata", 64'(P_DATA), 64'd0);
        chk("t6_rst_strobes", 64'({Data_Valid, parity_error, stop_error}), 64'd0);
        good_word = '0;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        rx_free = 0;
        repeat (3) @(negedge CLK);
        check_events("t6_abort");
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_events("t6_after");

        for (int n = 0; n < 20; n++) begin
            send_frame(DW'($urandom), 2 * $urandom_range(3, 31), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), 1'b1);
            check_events("rand");
            repeat ($urandom_range(2, 5)) @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
